// File: rtl/rx_block_assembler.sv
// rx_block_assembler: packs bytes from an RX FIFO into 64-bit DES blocks.
// The first byte received lands in bits [63:56]. A partial block is emitted
// zero-padded on flush or after TIMEOUT_CYCLES idle cycles (0 = no timeout).
// Ports:
//   clk, n_rst        clock, synchronous active-low reset
//   fifo_empty        RX FIFO empty flag
//   fifo_read_data    RX FIFO head byte
//   fifo_read_enable  pop strobe (combinational), head consumed on same edge
//   flush             single-cycle request to emit a partial block
//   blk_data          assembled block
//   blk_valid         blk_data holds a block for the DES core
//   blk_ready         DES core accepts the block
//   blk_padded        presented block was zero-padded
//   byte_count        bytes held in the current partial block
module rx_block_assembler #(
  parameter int unsigned TIMEOUT_CYCLES = 255
) (
  input  logic        clk,
  input  logic        n_rst,
  input  logic        fifo_empty,
  input  logic [7:0]  fifo_read_data,
  output logic        fifo_read_enable,
  input  logic        flush,
  output logic [63:0] blk_data,
  output logic        blk_valid,
  input  logic        blk_ready,
  output logic        blk_padded,
  output logic [2:0]  byte_count
);

  localparam int unsigned IDLE_W = (TIMEOUT_CYCLES > 0) ? $clog2(TIMEOUT_CYCLES + 1) : 1;

  typedef enum logic {
    FILL    = 1'b0,
    PRESENT = 1'b1
  } state_t;

  state_t            state;
  state_t            state_next;
  logic [IDLE_W-1:0] idle_cnt;
  logic [IDLE_W-1:0] idle_next;
  logic [63:0]       data_next;
  logic              valid_next;
  logic              padded_next;
  logic [2:0]        count_next;
  logic [3:0]        fill_level;
  logic [5:0]        lane_lsb;
  logic              timeout_hit;

  // Pop only while filling; gated by reset so a reset cycle never consumes a byte.
  assign fifo_read_enable = n_rst && (state == FILL) && !fifo_empty;

  // Next-state and next-output logic.
  always_comb begin
    state_next  = state;
    data_next   = blk_data;
    valid_next  = blk_valid;
    padded_next = blk_padded;
    count_next  = byte_count;
    idle_next   = idle_cnt;
    timeout_hit = 1'b0;
    // Bytes held once this cycle's pop (if any) is included.
    fill_level  = {1'b0, byte_count} + 4'(fifo_read_enable);
    // Lane n occupies bits [63-8n -: 8]; ~n equals 7-n for a 3-bit count.
    lane_lsb    = {~byte_count, 3'b000};

    case (state)
      FILL: begin
        if (fifo_read_enable) begin
          data_next[lane_lsb +: 8] = fifo_read_data;
        end
        if ((TIMEOUT_CYCLES > 0) && (byte_count != 3'd0) && !fifo_read_enable &&
            ((32'(idle_cnt) + 32'd1) >= TIMEOUT_CYCLES)) begin
          timeout_hit = 1'b1;
        end

        if (fill_level == 4'd8) begin
          state_next  = PRESENT;
          valid_next  = 1'b1;
          padded_next = 1'b0;
          count_next  = 3'd0;
          idle_next   = '0;
        end else if ((flush || timeout_hit) && (fill_level != 4'd0)) begin
          // Unfilled lanes are already zero: the block register is cleared
          // on every handshake and on reset.
          state_next  = PRESENT;
          valid_next  = 1'b1;
          padded_next = 1'b1;
          count_next  = 3'd0;
          idle_next   = '0;
        end else begin
          count_next = fill_level[2:0];
          if (fifo_read_enable || (byte_count == 3'd0)) begin
            idle_next = '0;
          end else if (32'(idle_cnt) < TIMEOUT_CYCLES) begin
            idle_next = idle_cnt + IDLE_W'(1);
          end
        end
      end

      PRESENT: begin
        // Flush is ignored here; only the handshake leaves this state.
        if (blk_valid && blk_ready) begin
          state_next  = FILL;
          data_next   = 64'd0;
          valid_next  = 1'b0;
          padded_next = 1'b0;
          count_next  = 3'd0;
          idle_next   = '0;
        end
      end
    endcase
  end

  // State register.
  always_ff @(posedge clk) begin
    if (!n_rst) begin
      state <= FILL;
    end else begin
      state <= state_next;
    end
  end

  // Output and idle-counter registers.
  always_ff @(posedge clk) begin
    if (!n_rst) begin
      blk_data   <= 64'd0;
      blk_valid  <= 1'b0;
      blk_padded <= 1'b0;
      byte_count <= 3'd0;
      idle_cnt   <= '0;
    end else begin
      blk_data   <= data_next;
      blk_valid  <= valid_next;
      blk_padded <= padded_next;
      byte_count <= count_next;
      idle_cnt   <= idle_next;
    end
  end

endmodule
